// File: rtl/audio_delay_line_pkg.sv
// ---------------------------------------------------------------------------
// audio_delay_pkg
// Shared helpers for the audio delay line:
//   mid_of      - midscale (silence) code of an offset-binary sample width
//   sat_add     - signed add saturated to the signed range of a sample width
//   clamp_delay - map a requested delay onto the legal range 1..depth-1
// ---------------------------------------------------------------------------
package audio_delay_pkg;

  function automatic int mid_of(input int data_w);
    return 32'sd1 <<< (data_w - 32'sd1);
  endfunction

  function automatic int sat_add(input int a, input int b, input int data_w);
    int hi;
    int lo;
    int sum;
    hi  = mid_of(data_w) - 32'sd1;
    lo  = -mid_of(data_w);
    sum = a + b;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end else begin
      return sum;
    end
  endfunction

  // A zero delay would read the slot being written, so it is bumped to one.
  function automatic int unsigned clamp_delay(input int unsigned len, input int unsigned depth);
    if (len == 32'd0) begin
      return 32'd1;
    end else if (len >= depth) begin
      return depth - 32'd1;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/audio_delay_line_if.sv
// ---------------------------------------------------------------------------
// audio_delay_line_if
// Sample-stream bus of the delay line.
//   sample_en  - one-cycle strobe per audio sample
//   delay_len  - requested delay in samples
//   data_in    - input sample (offset binary)
//   data_out   - delayed sample (registered)
//   valid_out  - pulse when data_out updates
// master: sample source / sink side, slave: the delay line.
// ---------------------------------------------------------------------------
interface audio_delay_line_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 16
);
  logic              sample_en;
  logic [ADDR_W-1:0] delay_len;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  modport master (
    output sample_en, delay_len, data_in,
    input  data_out, valid_out
  );

  modport slave (
    input  sample_en, delay_len, data_in,
    output data_out, valid_out
  );
endinterface

// File: rtl/audio_delay_line_ram.sv
// ---------------------------------------------------------------------------
// delay_ram
// Simple dual-port RAM, DEPTH x DATA_W: one write port, one read port with a
// registered output. No reset so that it maps onto block RAM.
//   clk   - clock
//   we    - write enable,  waddr/wdata - write address / data
//   re    - read enable,   raddr       - read address
//   rd_q  - registered read data
// ---------------------------------------------------------------------------
module delay_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 40000,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_q
);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[MEM_AW-1:0]] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rd_q <= mem[raddr[MEM_AW-1:0]];
    end
  end
endmodule

// File: rtl/audio_delay_line.sv
// ---------------------------------------------------------------------------
// audio_delay_line
// Mono audio delay/echo line with runtime delay length. Each sample_en strobe
// writes one sample into a ring buffer and reads the sample written D strobes
// earlier; the result appears on data_out two clock edges after the strobe.
// Until D samples of history exist the output is midscale (silence).
// Ports:
//   CLOCK - system clock (posedge)
//   RESET - asynchronous active-high reset
//   bus   - audio_delay_line_if.slave (sample_en, delay_len, data_in,
//           data_out, valid_out)
// Build option: define ECHO_FEEDBACK_EN to add the registered output, shifted
// right by FB_SHIFT, back into the written sample (saturating echo).
// ---------------------------------------------------------------------------
module audio_delay_line
  import audio_delay_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 40000,
  parameter int ADDR_W   = 16,
  parameter int FB_SHIFT = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  audio_delay_line_if.slave bus
);
  localparam int                MID_I  = mid_of(DATA_W);
  localparam logic [DATA_W-1:0] MID    = DATA_W'(MID_I);
  localparam int                FILL_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              hist_ok_q, hist_ok_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;

  logic [ADDR_W-1:0] d_eff_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rd_q;

  // Effective delay and ring read address; wrap by adding DEPTH since DEPTH
  // need not be a power of two.
  always_comb begin
    d_eff_s = ADDR_W'(clamp_delay(32'(bus.delay_len), 32'(DEPTH)));
    if (wr_ptr_q < d_eff_s) begin
      rd_addr_s = wr_ptr_q + DEPTH_A - d_eff_s;
    end else begin
      rd_addr_s = wr_ptr_q - d_eff_s;
    end
  end

`ifdef ECHO_FEEDBACK_EN
  int s_in_s;
  int s_fb_s;

  // Echo feedback: the registered output is used, so the loop spans D+1 samples.
  always_comb begin
    s_in_s  = int'(bus.data_in) - MID_I;
    s_fb_s  = (int'(data_out_q) - MID_I) >>> FB_SHIFT;
    wdata_s = DATA_W'(sat_add(s_in_s, s_fb_s, DATA_W) + MID_I);
  end
`else
  assign wdata_s = bus.data_in;
`endif

  delay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLOCK),
    .we    (bus.sample_en),
    .waddr (wr_ptr_q),
    .wdata (wdata_s),
    .re    (bus.sample_en),
    .raddr (rd_addr_s),
    .rd_q  (rd_q)
  );

  // Pointer/fill advance on each strobe and output stage one cycle later.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    hist_ok_d   = hist_ok_q;
    rd_vld_d    = bus.sample_en;
    data_out_d  = data_out_q;
    valid_out_d = rd_vld_q;
    if (bus.sample_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_A) ? '0 : wr_ptr_q + ADDR_W'(1);
      if (fill_cnt_q != DEPTH_F) begin
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
      end else begin
        fill_cnt_d = fill_cnt_q;
      end
      // fill_cnt before this write: the read slot holds real data only if
      // at least D samples were written since reset.
      hist_ok_d = (fill_cnt_q >= {1'b0, d_eff_s});
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_vld_q) begin
      data_out_d = hist_ok_q ? rd_q : MID;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // State registers
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      hist_ok_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      data_out_q  <= MID;
      valid_out_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      hist_ok_q   <= hist_ok_d;
      rd_vld_q    <= rd_vld_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
endmodule

// File: tb/tb_audio_delay_line.sv
// ---------------------------------------------------------------------------
// tb_audio_delay_line
// Directed + randomized bench for audio_delay_line (DEPTH=16, ADDR_W=5,
// DATA_W=12). The reference model keeps every sample written since reset in
// a queue; the expected output of strobe k is the sample of strobe k-D, or
// midscale when k < D.
// ---------------------------------------------------------------------------
module tb_audio_delay_line;
  localparam int DW = 12;
  localparam int AW = 5;
  localparam int DP = 16;
  localparam logic [DW-1:0] MID = 12'd2048;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [DW-1:0] wq[$];
  logic [DW-1:0] dout_m;

  audio_delay_line_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  audio_delay_line #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .ADDR_W   (AW),
    .FB_SHIFT (1)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: record the written sample and return the expected output.
  task automatic model_step(input int len, input logic [DW-1:0] din, output logic [DW-1:0] exp);
    int d;
    int k;
    int sum;
    logic [DW-1:0] w;
    d = (len < 1) ? 1 : ((len > DP - 1) ? DP - 1 : len);
    sum = 0;
`ifdef ECHO_FEEDBACK_EN
    sum = (int'(din) - 2048) + ((int'(dout_m) - 2048) >>> 1);
    if (sum > 2047) sum = 2047;
    if (sum < -2048) sum = -2048;
    w = 12'(sum + 2048);
`else
    w = din;
`endif
    k = wq.size();
    wq.push_back(w);
    exp = (k >= d) ? wq[k - d] : MID;
  endtask

  // One isolated strobe; output checked two edges later.
  task automatic strobe(input int len, input logic [DW-1:0] din, output logic [DW-1:0] obs);
    logic [DW-1:0] e;
    model_step(len, din, e);
    bus.sample_en = 1'b1;
    bus.delay_len = 5'(len);
    bus.data_in   = din;
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    chk("vld_early", 32'(bus.valid_out), 32'd0);
    @(posedge clk); #1;
    chk("vld", 32'(bus.valid_out), 32'd1);
    chk("data", 32'(bus.data_out), 32'(e));
    obs = bus.data_out;
    dout_m = e;
  endtask

  task automatic rand_strobes(input int n, input int len);
    logic [DW-1:0] o;
    for (int i = 0; i < n; i++) begin
      strobe(len, 12'($urandom_range(0, 4095)), o);
    end
  endtask

  // Back-to-back strobes; each cycle is a full sample.
  task automatic burst(input int n);
    logic [DW-1:0] e;
    logic [DW-1:0] e_prev;
    logic [DW-1:0] din;
    int l;
    e_prev = MID;
    for (int i = 0; i < n; i++) begin
      l   = int'($urandom_range(0, 31));
      din = 12'($urandom_range(0, 4095));
      model_step(l, din, e);
      bus.sample_en = 1'b1;
      bus.delay_len = 5'(l);
      bus.data_in   = din;
      @(posedge clk); #1;
      if (i > 0) begin
        chk("burst_vld", 32'(bus.valid_out), 32'd1);
        chk("burst_data", 32'(bus.data_out), 32'(e_prev));
        dout_m = e_prev;
      end
      e_prev = e;
    end
    bus.sample_en = 1'b0;
    @(posedge clk); #1;
    chk("burst_vld_last", 32'(bus.valid_out), 32'd1);
    chk("burst_data_last", 32'(bus.data_out), 32'(e_prev));
    dout_m = e_prev;
    @(posedge clk); #1;
    chk("burst_vld_end", 32'(bus.valid_out), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_data", 32'(bus.data_out), 32'(MID));
    chk("rst_vld", 32'(bus.valid_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete();
    dout_m = MID;
  endtask

  initial begin
    logic [DW-1:0] o;
    logic [DW-1:0] outs[12];
    n_checks = 0;
    n_errors = 0;
    dout_m = MID;
    rst = 1'b1;
    bus.sample_en = 1'b0;
    bus.delay_len = '0;
    bus.data_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", 32'(bus.data_out), 32'(MID));
    chk("reset_vld", 32'(bus.valid_out), 32'd0);
    rst = 1'b0;

    // Ramp with D=4: four silent pulses then 1,2,3...
    for (int i = 1; i <= 12; i++) begin
      strobe(4, 12'(i), o);
      if (i == 4) chk("ramp_silent4", 32'(o), 32'(MID));
      if (i == 5) chk("ramp_first", 32'(o), 32'd1);
    end

    // Clamp: 0 behaves as 1, 20 behaves as 15.
    do_reset();
    for (int i = 1; i <= 6; i++) strobe(0, 12'(100 + i), o);
    chk("d0_is_1", 32'(o), 32'd105);
    for (int i = 1; i <= 20; i++) strobe(20, 12'(200 + i), o);
    rand_strobes(5, 20);

    // Long run at D=15 across several pointer wraps.
    do_reset();
    rand_strobes(40, 15);

    // Short delay then a longer one that outruns the history.
    do_reset();
    rand_strobes(10, 3);
    rand_strobes(14, 12);

    // Back-to-back strobes with random delays.
    burst(24);

    // Idle: registers hold and valid stays low.
    repeat (5) @(posedge clk);
    #1;
    chk("idle_data", 32'(bus.data_out), 32'(dout_m));
    chk("idle_vld", 32'(bus.valid_out), 32'd0);

    // Reset between strobes, then stale RAM must stay hidden.
    rand_strobes(6, 3);
    do_reset();
    rand_strobes(6, 3);

    // Reset while a strobe is in flight.
    model_step(3, 12'd1234, o);
    bus.sample_en = 1'b1;
    bus.delay_len = 5'd3;
    bus.data_in   = 12'd1234;
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    do_reset();
    chk("rst_fly_vld", 32'(bus.valid_out), 32'd0);
    rand_strobes(8, 5);

`ifdef ECHO_FEEDBACK_EN
    // Impulse through the echo loop, D=3.
    do_reset();
    strobe(3, 12'd3000, outs[0]);
    for (int i = 1; i < 12; i++) strobe(3, MID, outs[i]);
    chk("echo_first", 32'(outs[3]), 32'd3000);
    chk("echo_second", 32'(outs[7]), 32'd2524);
    // Full-scale input plus positive feedback saturates.
    do_reset();
    strobe(3, 12'd3000, o);
    for (int i = 0; i < 3; i++) strobe(3, MID, o);
    strobe(3, 12'd4095, o);
    for (int i = 0; i < 3; i++) strobe(3, MID, outs[i]);
    chk("echo_sat", 32'(outs[2]), 32'd4095);
`else
    outs[0] = MID;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
